psum_mux_acc: RTL and testbench

//  Receiving end of the MAC->MUX partial-sum interface (MACMUX_Val/Addr/Psum, MUXMAC_Rdy).

---
 rtl/psum_mux_acc.sv | 102 ++++++++++
 tb/tb_psum_mux_acc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/psum_mux_acc.sv
// psum_mux_acc: round-robin MAC psum arbiter feeding a row-wide accumulating psum register file.
// Optional PSUM_SAT_EN: saturating accumulate plus sticky MUXPEB_Ovf status.
module psum_mux_acc #(
  parameter int NUM_MAC    = 3,
  parameter int PSUM_WIDTH = 24,
  parameter int ADDR_WIDTH = 5,
  parameter int ROW_LEN    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MAC-1:0]               MACMUX_Val,
  input  logic [NUM_MAC*ADDR_WIDTH-1:0]    MACMUX_Addr,
  input  logic [NUM_MAC*PSUM_WIDTH-1:0]    MACMUX_Psum,
  output logic [NUM_MAC-1:0]               MUXMAC_Rdy,
  input  logic                             PEBMUX_Clr,
  input  logic                             PEBMUX_RdEn,
  input  logic [ADDR_WIDTH-1:0]            PEBMUX_RdAddr,
  output logic                             MUXPEB_RdVal,
  output logic [PSUM_WIDTH-1:0]            MUXPEB_RdPsum,
`ifdef PSUM_SAT_EN
  output logic                             MUXPEB_Ovf,
`endif
  output logic                             MUXPEB_Idle
);
  localparam int RW = NUM_MAC > 1 ? $clog2(NUM_MAC) : 1;
  localparam int LW = ROW_LEN > 1 ? $clog2(ROW_LEN) : 1;
  localparam int PW = PSUM_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] ROW_LIM = (AW+1)'(ROW_LEN);
  logic [RW-1:0]      rr_q, rr_d;
  logic               pv_q;
  logic [AW-1:0]      pa_q, pa_d;
  logic [PW-1:0]      pp_q, pp_d;
  logic [ROW_LEN-1:0] vld_q;
  logic [PW-1:0]      ent_q [ROW_LEN];
  logic               xfer, wr, rd_in;
  logic [LW-1:0]      wi, ri;
  logic [PW-1:0]      old, sum, res;
  int                 j;
  always_comb begin
    MUXMAC_Rdy = '0;
    rr_d = rr_q;
    pa_d = pa_q;
    pp_d = pp_q;
    xfer = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_MAC; k++) begin
      j = (int'(rr_q) + k) % NUM_MAC;
      if (!xfer && !PEBMUX_Clr && MACMUX_Val[j]) begin
        MUXMAC_Rdy[j] = 1'b1;
        xfer = 1'b1;
        rr_d = RW'((j + 1) % NUM_MAC);
        pa_d = MACMUX_Addr[j*AW +: AW];
        pp_d = MACMUX_Psum[j*PW +: PW];
      end
    end
  end
  assign wi    = pa_q[LW-1:0];
  assign wr    = pv_q && ({1'b0, pa_q} < ROW_LIM);
  assign old   = vld_q[wi] ? ent_q[wi] : '0;
  assign sum   = old + pp_q;
  assign ri    = PEBMUX_RdAddr[LW-1:0];
  assign rd_in = {1'b0, PEBMUX_RdAddr} < ROW_LIM;
  assign MUXPEB_Idle = ~|MACMUX_Val && ~pv_q;
`ifdef PSUM_SAT_EN
  logic ovf;
  // Signed overflow only when both operands share a sign the result lost; clamp toward that sign.
  assign ovf = (old[PW-1] == pp_q[PW-1]) && (sum[PW-1] != old[PW-1]);
  assign res = ovf ? {old[PW-1], {(PW-1){~old[PW-1]}}} : sum;
`else
  assign res = sum;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= '0;
      pv_q          <= 1'b0;
      pa_q          <= '0;
      pp_q          <= '0;
      vld_q         <= '0;
      MUXPEB_RdVal  <= 1'b0;
      MUXPEB_RdPsum <= '0;
`ifdef PSUM_SAT_EN
      MUXPEB_Ovf    <= 1'b0;
`endif
    end else begin
      rr_q          <= rr_d;
      pa_q          <= pa_d;
      pp_q          <= pp_d;
      pv_q          <= xfer;
      vld_q         <= PEBMUX_Clr ? '0 : wr ? vld_q | (ROW_LEN'(1) << wi) : vld_q;
      MUXPEB_RdVal  <= PEBMUX_RdEn;
      MUXPEB_RdPsum <= (rd_in && vld_q[ri]) ? ent_q[ri] : '0;
`ifdef PSUM_SAT_EN
      MUXPEB_Ovf    <= !PEBMUX_Clr && (MUXPEB_Ovf || (wr && ovf));
`endif
    end
  end
  // Entry data needs no reset: the valid bits mask it.
  always_ff @(posedge clk) begin
    if (wr) ent_q[wi] <= res;
  end
endmodule

// File: tb/tb_psum_mux_acc.sv
// tb_psum_mux_acc: directed and randomized checks of psum_mux_acc against an array-based reference model.
module tb_psum_mux_acc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  val = '0;
  logic [4:0]  addr [3];
  logic [23:0] psum [3];
  logic        clr = 1'b0, rden = 1'b0;
  logic [4:0]  rda = '0;
  logic [2:0]  rdy;
  logic        rdval, idle;
  logic [23:0] rdpsum;
`ifdef PSUM_SAT_EN
  logic        ovf;
`endif
  int n_vec = 0, n_err = 0;
  int          m_rr;
  bit          m_pv, m_ovf;
  logic [4:0]  m_pa;
  logic [23:0] m_pp;
  bit          m_vld [16];
  logic [23:0] m_ent [16];
  logic [2:0]  last_rdy;
  logic [23:0] last_rd;

  always #5 clk = ~clk;

  psum_mux_acc dut (
    .clk(clk), .rst_n(rst_n),
    .MACMUX_Val(val), .MACMUX_Addr({addr[2], addr[1], addr[0]}),
    .MACMUX_Psum({psum[2], psum[1], psum[0]}), .MUXMAC_Rdy(rdy),
    .PEBMUX_Clr(clr), .PEBMUX_RdEn(rden), .PEBMUX_RdAddr(rda),
    .MUXPEB_RdVal(rdval), .MUXPEB_RdPsum(rdpsum),
`ifdef PSUM_SAT_EN
    .MUXPEB_Ovf(ovf),
`endif
    .MUXPEB_Idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_pv = 0; m_ovf = 0; m_pa = '0; m_pp = '0;
    for (int i = 0; i < 16; i++) begin m_vld[i] = 0; m_ent[i] = '0; end
  endtask

  task automatic do_reset();
    val = '0; clr = 0; rden = 0;
    rst_n = 0;
    #2;
    chk("rst_rdy", rdy, 0);
    chk("rst_idle", idle, 1);
    chk("rst_rdval", rdval, 0);
    chk("rst_rdpsum", rdpsum, 0);
`ifdef PSUM_SAT_EN
    chk("rst_ovf", ovf, 0);
`endif
    model_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic cyc();
    int g;
    logic [2:0] eg;
    logic [23:0] rp, o;
    bit er;
    longint s;
    #1;
    g = -1;
    if (!clr)
      for (int k = 0; k < 3; k++)
        if (g < 0 && val[(m_rr + k) % 3]) g = (m_rr + k) % 3;
    eg = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("rdy", rdy, eg);
    last_rdy = rdy;
    chk("idle", idle, !(|val) && !m_pv);
    er = rden;
    rp = m_vld[rda[3:0]] ? m_ent[rda[3:0]] : 24'h0;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_vld[i] = 0;
      m_pv = 0; m_ovf = 0;
    end else begin
      if (m_pv && m_pa < 16) begin
        o = m_vld[m_pa[3:0]] ? m_ent[m_pa[3:0]] : 24'h0;
        s = $signed(o) + $signed(m_pp);
`ifdef PSUM_SAT_EN
        if (s > 64'sd8388607) begin s = 64'sd8388607; m_ovf = 1; end
        else if (s < -64'sd8388608) begin s = -64'sd8388608; m_ovf = 1; end
`endif
        m_ent[m_pa[3:0]] = s[23:0];
        m_vld[m_pa[3:0]] = 1;
      end
      m_pv = (g >= 0);
      if (g >= 0) begin m_pa = addr[g]; m_pp = psum[g]; m_rr = (g + 1) % 3; end
    end
    @(posedge clk); #1;
    if (g >= 0) val[g] = 1'b0;
    clr = 0; rden = 0;
    chk("rdval", rdval, er);
    if (er) chk("rdpsum", rdpsum, rp);
    last_rd = rdpsum;
`ifdef PSUM_SAT_EN
    chk("ovf", ovf, m_ovf);
`endif
  endtask

  task automatic send(input int l, input logic [4:0] a, input logic [23:0] p);
    val[l] = 1'b1; addr[l] = a; psum[l] = p;
  endtask

  task automatic rd(input logic [4:0] a, input logic [23:0] exp);
    rden = 1; rda = a;
    cyc();
    chk("rd_const", last_rd, exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin addr[i] = '0; psum[i] = '0; end
    #3 do_reset();
    clr = 1; cyc();
    send(0, 5'd3, 24'd5); cyc();
    send(0, 5'd3, 24'd7); cyc();
    repeat (2) cyc();
    rd(5'd3, 24'd12);

    do_reset();
    send(0, 5'd0, 24'd1); send(1, 5'd0, 24'd2); send(2, 5'd0, 24'd3);
    cyc(); chk("rr_g0", last_rdy, 3'b001);
    cyc(); chk("rr_g1", last_rdy, 3'b010);
    cyc(); chk("rr_g2", last_rdy, 3'b100);
    repeat (2) cyc();
    rd(5'd0, 24'd6);

    do_reset();
    send(2, 5'h1F, 24'd100);
    cyc(); chk("oor_g", last_rdy, 3'b100);
    cyc(); chk("oor_one", last_rdy, 3'b000);
    for (int a = 0; a < 16; a++) rd(5'(a), 24'd0);

    do_reset();
    send(1, 5'd4, 24'd9); clr = 1;
    cyc(); chk("clr_nogrant", last_rdy, 3'b000);
    cyc(); chk("clr_next", last_rdy, 3'b010);
    repeat (2) cyc();
    rd(5'd4, 24'd9);

    send(0, 5'd2, 24'd4); cyc();
    clr = 1; cyc();
    repeat (2) cyc();
    rd(5'd2, 24'd0);

    send(0, 5'd1, 24'h7FFFF0); cyc();
    send(0, 5'd1, 24'h000020); cyc();
    repeat (2) cyc();
`ifdef PSUM_SAT_EN
    rd(5'd1, 24'h7FFFFF);
    chk("sat_ovf", ovf, 1);
`else
    rd(5'd1, 24'h800010);
`endif

    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < 3; l++)
        if (!val[l] && $urandom_range(0, 1) == 1) begin
          addr[l] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
          psum[l] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 255) - 128);
          val[l] = 1'b1;
        end
      clr  = ($urandom_range(0, 29) == 0);
      rden = ($urandom_range(0, 2) == 0);
      rda  = 5'($urandom_range(0, 15));
      if (c == 200) do_reset();
      else cyc();
    end
    val = '0;
    repeat (3) cyc();
    for (int a = 0; a < 16; a++) begin rden = 1; rda = 5'(a); cyc(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
